consumer: RTL and testbench
===========================

Name: consumer

Overview:
- Receiving end of the two-channel producer request interface: address, id and valid per channel, plus per-channel stall back-pressure and flush/flush_id.
- Buffers each channel in its own FIFO.
- Applies flush by killing queued requests whose id matches flush_id.
- Merges surviving requests onto one registered downstream port using round-robin arbitration with ready/valid handshake.

Parameters:
ADDR_W, `ADDRESS_WIDTH, request address width
ID_W, `ID_WIDTH, request/flush id width (8 in current configuration)
DEPTH, 4, entries per channel FIFO; power of two, >= 2
CNT_W, 8, width of drop counters

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
in_address_1  input  ADDR_W  channel 1 request address
in_id_1  input  ID_W  channel 1 request id
in_valid_1  input  1  channel 1 request valid
out_stall_1  output  1  back-pressure to channel 1 producer
flush_1  input  1  channel 1 flush strobe (one cycle)
flush_id_1  input  ID_W  id to kill on channel 1
in_address_2 / in_id_2 / in_valid_2 / out_stall_2 / flush_2 / flush_id_2  same as channel 1, for channel 2
out_address  output  ADDR_W  downstream request address
out_id  output  ID_W  downstream request id
out_channel  output  1  0 = channel 1, 1 = channel 2
out_valid  output  1  downstream valid
out_ready  input  1  downstream ready
drop_cnt_1  output  CNT_W  requests killed by flush_1, wrapping
drop_cnt_2  output  CNT_W  requests killed by flush_2, wrapping

Behaviour:
- Reset: all FIFOs empty with pointers 0; all kill bits 0; out_valid, out_address, out_id, out_channel = 0; drop counters 0; out_stall_n = 0; rr_last = channel 2, so channel 1 wins the first tie.
- Stall: out_stall_n is combinational, equal to (count_n == DEPTH).
  - No same-cycle bypass: stall stays high on a full cycle even if the head pops.
- Enqueue: at posedge, when in_valid_n && !out_stall_n, write {address, id, kill=0}, then wptr++ and count++.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - in_valid_n low: nothing written.
- Flush (per channel, sampled at posedge when flush_n = 1):
  - Every occupied entry in FIFO n with id == flush_id_n gets kill set.
  - An entry enqueued in the same cycle with matching id is written with kill = 1.
  - If the output register holds a channel-n request with matching id and no handshake completes this cycle, out_valid clears at that edge.
  - If the handshake completes this cycle, the transfer stands and is not counted as killed.
  - drop_cnt_n adds the number of entries newly killed, including the output register. Already-killed entries are not recounted.
  - Flush never alters out_stall_n directly.
- Head disposal:
  - A killed head is popped in one cycle with no output; count--.
  - Both heads killed: both pop in the same cycle.
- Output register load (loadable = !out_valid || out_ready):
  - Live heads are the non-empty heads with kill = 0.
  - When loadable and at least one head is live, the arbiter grants one head, pops it and loads address, id and channel; out_valid = 1.
  - When loadable and no head is live, out_valid = 0.
  - Arbitration: if both heads are live, grant the channel != rr_last; otherwise grant the single live head. rr_last updates on every grant.
  - A killed head on the other channel may pop in the same cycle as a grant.
- Latency: a request accepted at edge T is visible on out_* after edge T+1 at the earliest, given an empty FIFO, a loadable output and a won arbitration.
- out_* hold stable while out_valid && !out_ready.
- Simultaneous enqueue and pop on one FIFO: count unchanged, both pointers advance.
- Reset asserted mid-operation immediately clears all state and outputs to their reset values. Queued requests are discarded and not counted.
- Ordering: per-channel order is preserved. Cross-channel order follows only from the arbitration rule.

Test Plan:
- Reset, then channel 1 presents id 8'h11 addr 4 with out_ready = 1 -> out_valid after the next edge with out_id 8'h11, out_address 4, out_channel 0; out_stall_1 stays 0.
- out_ready = 0, channel 1 streams ids 8'h11 to 8'h15 -> out register holds 8'h11; 4 more are accepted; out_stall_1 = 1 once count = 4; 8'h16 is held by the producer. Raise out_ready -> 8'h12 to 8'h16 follow in order, stall drops.
- Queue holds 8'h13 to 8'h16 with out_ready = 0; pulse flush_1 with flush_id_1 = 8'h16 -> drop_cnt_1 = 1; 8'h16 is never output; the other three are output in order.
- flush_1 id matches the output register (8'h12) with out_ready = 0 -> out_valid clears, drop_cnt_1 increments. Repeat with out_ready = 1 in the same cycle -> 8'h12 transfers, drop_cnt_1 unchanged.
- Both channels continuously valid (ids 8'h1x and 8'h2x) with out_ready = 1 -> out_channel alternates 0, 1, 0, 1, starting with 0 after reset.
- Reset asserted asynchronously with both FIFOs partially full -> all outputs are 0 immediately; after release, the first output is the next new request.

Source files
------------

// File: rtl/consumer_if.sv
// Producer-side request channels and the merged downstream port of the consumer.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

interface consumer_if #(
    parameter int ADDR_W = `ADDRESS_WIDTH,
    parameter int ID_W   = `ID_WIDTH
) ();
    logic [ADDR_W-1:0] in_address_1;
    logic [ID_W-1:0]   in_id_1;
    logic              in_valid_1;
    logic              out_stall_1;
    logic              flush_1;
    logic [ID_W-1:0]   flush_id_1;

    logic [ADDR_W-1:0] in_address_2;
    logic [ID_W-1:0]   in_id_2;
    logic              in_valid_2;
    logic              out_stall_2;
    logic              flush_2;
    logic [ID_W-1:0]   flush_id_2;

    logic [ADDR_W-1:0] out_address;
    logic [ID_W-1:0]   out_id;
    logic              out_channel;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  in_address_1, in_id_1, in_valid_1, flush_1, flush_id_1,
        input  in_address_2, in_id_2, in_valid_2, flush_2, flush_id_2,
        input  out_ready,
        output out_stall_1, out_stall_2,
        output out_address, out_id, out_channel, out_valid
    );

    modport master (
        output in_address_1, in_id_1, in_valid_1, flush_1, flush_id_1,
        output in_address_2, in_id_2, in_valid_2, flush_2, flush_id_2,
        output out_ready,
        input  out_stall_1, out_stall_2,
        input  out_address, out_id, out_channel, out_valid
    );
endinterface

// File: rtl/consumer.sv
// Two-channel request consumer: per-channel FIFOs with id-based flush,
// round-robin merge onto one registered ready/valid output.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

module consumer #(
    parameter int ADDR_W = `ADDRESS_WIDTH,
    parameter int ID_W   = `ID_WIDTH,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    consumer_if.slave        bus,
    output logic [CNT_W-1:0] drop_cnt_1,
    output logic [CNT_W-1:0] drop_cnt_2
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned NENT  = DEPTH;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;
    localparam cnt_t FULL = cnt_t'(DEPTH);

    logic [ADDR_W-1:0] r_addr  [2][NENT];
    logic [ID_W-1:0]   r_id    [2][NENT];
    logic [NENT-1:0]   r_kill  [2];
    ptr_t              r_wptr  [2];
    ptr_t              r_rptr  [2];
    cnt_t              r_count [2];
    logic [CNT_W-1:0]  r_drop  [2];

    logic              r_out_valid;
    logic              r_out_channel;
    logic [ADDR_W-1:0] r_out_address;
    logic [ID_W-1:0]   r_out_id;
    logic              r_rr_last;

    logic [ADDR_W-1:0] w_in_addr  [2];
    logic [ID_W-1:0]   w_in_id    [2];
    logic [ID_W-1:0]   w_flush_id [2];
    logic [1:0]        w_in_valid;
    logic [1:0]        w_flush;
    logic [1:0]        w_stall;
    logic [1:0]        w_push;
    logic [1:0]        w_live;
    logic [1:0]        w_head_dead;
    logic [1:0]        w_push_hit;
    logic [1:0]        w_out_hit;
    logic [1:0]        w_pop;
    logic [NENT-1:0]   w_hit      [2];
    logic [CNT_W-1:0]  w_drop_inc [2];
    logic              w_loadable;
    logic              w_grant_any;
    logic              w_grant_ch;
    logic [ADDR_W-1:0] w_grant_addr;
    logic [ID_W-1:0]   w_grant_id;

    // Gather the interface signals into channel-indexed form
    always_comb begin
        w_in_addr[0]  = bus.in_address_1;
        w_in_addr[1]  = bus.in_address_2;
        w_in_id[0]    = bus.in_id_1;
        w_in_id[1]    = bus.in_id_2;
        w_in_valid    = {bus.in_valid_2, bus.in_valid_1};
        w_flush       = {bus.flush_2, bus.flush_1};
        w_flush_id[0] = bus.flush_id_1;
        w_flush_id[1] = bus.flush_id_2;
    end

    // Per-channel stall, push qualification, head status and flush hits
    always_comb begin
        ptr_t w_off;
        logic w_head_match;
        w_off        = '0;
        w_head_match = 1'b0;
        w_stall      = '0;
        w_push       = '0;
        w_live       = '0;
        w_head_dead  = '0;
        w_push_hit   = '0;
        w_out_hit    = '0;
        for (int unsigned c = 0; c < 2; c++) begin
            w_hit[1'(c)]      = '0;
            w_drop_inc[1'(c)] = '0;
            w_stall[1'(c)]    = (r_count[1'(c)] == FULL);
            w_push[1'(c)]     = w_in_valid[1'(c)] && !w_stall[1'(c)];
            // A live head hit by a flush this cycle is withheld from arbitration;
            // it is marked killed at this edge and disposed of on the next.
            w_head_match      = w_flush[1'(c)] &&
                                (r_id[1'(c)][r_rptr[1'(c)]] == w_flush_id[1'(c)]);
            w_head_dead[1'(c)] = (r_count[1'(c)] != '0) && r_kill[1'(c)][r_rptr[1'(c)]];
            w_live[1'(c)]      = (r_count[1'(c)] != '0) && !r_kill[1'(c)][r_rptr[1'(c)]] &&
                                 !w_head_match;
            for (int unsigned i = 0; i < NENT; i++) begin
                w_off = ptr_t'(i) - r_rptr[1'(c)];
                if (w_flush[1'(c)] && ({1'b0, w_off} < r_count[1'(c)]) &&
                    !r_kill[1'(c)][ptr_t'(i)] &&
                    (r_id[1'(c)][ptr_t'(i)] == w_flush_id[1'(c)]))
                    w_hit[1'(c)][ptr_t'(i)] = 1'b1;
                w_drop_inc[1'(c)] = w_drop_inc[1'(c)] + CNT_W'(w_hit[1'(c)][ptr_t'(i)]);
            end
            w_push_hit[1'(c)] = w_flush[1'(c)] && w_push[1'(c)] &&
                                (w_in_id[1'(c)] == w_flush_id[1'(c)]);
            w_out_hit[1'(c)]  = w_flush[1'(c)] && r_out_valid && !bus.out_ready &&
                                (r_out_channel == 1'(c)) && (r_out_id == w_flush_id[1'(c)]);
            w_drop_inc[1'(c)] = w_drop_inc[1'(c)] + CNT_W'(w_push_hit[1'(c)]) +
                                CNT_W'(w_out_hit[1'(c)]);
        end
    end

    // Round-robin grant between live heads and pop selection
    always_comb begin
        w_loadable  = !r_out_valid || bus.out_ready;
        w_grant_any = w_loadable && (|w_live);
        if (&w_live)
            w_grant_ch = !r_rr_last;
        else
            w_grant_ch = w_live[1];
        w_grant_addr = r_addr[w_grant_ch][r_rptr[w_grant_ch]];
        w_grant_id   = r_id[w_grant_ch][r_rptr[w_grant_ch]];
        w_pop[0]     = w_head_dead[0] || (w_grant_any && !w_grant_ch);
        w_pop[1]     = w_head_dead[1] || (w_grant_any && w_grant_ch);
    end

    // Drive the interface outputs and drop counters
    always_comb begin
        bus.out_stall_1 = w_stall[0];
        bus.out_stall_2 = w_stall[1];
        bus.out_valid   = r_out_valid;
        bus.out_channel = r_out_channel;
        bus.out_address = r_out_address;
        bus.out_id      = r_out_id;
        drop_cnt_1      = r_drop[0];
        drop_cnt_2      = r_drop[1];
    end

    // FIFO payload storage, written on accepted requests
    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < 2; c++) begin
            if (w_push[1'(c)]) begin
                r_addr[1'(c)][r_wptr[1'(c)]] <= w_in_addr[1'(c)];
                r_id[1'(c)][r_wptr[1'(c)]]   <= w_in_id[1'(c)];
            end
        end
    end

    // FIFO pointers, occupancy, kill marks and drop counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned c = 0; c < 2; c++) begin
                r_wptr[1'(c)]  <= '0;
                r_rptr[1'(c)]  <= '0;
                r_count[1'(c)] <= '0;
                r_kill[1'(c)]  <= '0;
                r_drop[1'(c)]  <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < 2; c++) begin
                for (int unsigned i = 0; i < NENT; i++) begin
                    if (w_hit[1'(c)][ptr_t'(i)])
                        r_kill[1'(c)][ptr_t'(i)] <= 1'b1;
                end
                if (w_push[1'(c)]) begin
                    r_kill[1'(c)][r_wptr[1'(c)]] <= w_push_hit[1'(c)];
                    r_wptr[1'(c)] <= r_wptr[1'(c)] + ptr_t'(1);
                end
                if (w_pop[1'(c)])
                    r_rptr[1'(c)] <= r_rptr[1'(c)] + ptr_t'(1);
                case ({w_push[1'(c)], w_pop[1'(c)]})
                    2'b10:   r_count[1'(c)] <= r_count[1'(c)] + cnt_t'(1);
                    2'b01:   r_count[1'(c)] <= r_count[1'(c)] - cnt_t'(1);
                    default: r_count[1'(c)] <= r_count[1'(c)];
                endcase
                r_drop[1'(c)] <= r_drop[1'(c)] + w_drop_inc[1'(c)];
            end
        end
    end

    // Downstream output register and round-robin history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid   <= 1'b0;
            r_out_channel <= 1'b0;
            r_out_address <= '0;
            r_out_id      <= '0;
            r_rr_last     <= 1'b1;
        end else if (w_loadable) begin
            if (w_grant_any) begin
                r_out_valid   <= 1'b1;
                r_out_channel <= w_grant_ch;
                r_out_address <= w_grant_addr;
                r_out_id      <= w_grant_id;
                r_rr_last     <= w_grant_ch;
            end else begin
                r_out_valid   <= 1'b0;
            end
        end else if (|w_out_hit) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_consumer.sv
// Directed bench for consumer: per-channel scoreboard queues filled on
// accepted requests, trimmed on flush, and popped on output handshakes.
`timescale 1ns/1ps

module tb_consumer;
    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  id;
    } item_t;

    logic       clk;
    logic       reset;
    logic [7:0] drop_cnt_1;
    logic [7:0] drop_cnt_2;

    item_t q1[$];
    item_t q2[$];
    bit    hist[$];
    int    exp_drop1;
    int    exp_drop2;
    int    total;
    int    bad;
    bit    acc1;
    bit    acc2;

    consumer_if #(.ADDR_W(16), .ID_W(8)) bus ();

    consumer #(
        .ADDR_W(16),
        .ID_W  (8),
        .DEPTH (4),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .drop_cnt_1(drop_cnt_1),
        .drop_cnt_2(drop_cnt_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set1(input bit v, input logic [7:0] id, input logic [15:0] a);
        bus.in_valid_1   = v;
        bus.in_id_1      = id;
        bus.in_address_1 = a;
    endtask

    task automatic set2(input bit v, input logic [7:0] id, input logic [15:0] a);
        bus.in_valid_2   = v;
        bus.in_id_2      = id;
        bus.in_address_2 = a;
    endtask

    // Sample mid-cycle, update the model for the coming edge, then advance.
    task automatic tick();
        item_t it;
        int    n;
        @(negedge clk);
        acc1 = 1'b0;
        acc2 = 1'b0;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            hist.push_back(bus.out_channel);
            if (bus.out_channel === 1'b0) begin
                check("ch1_expected_item", 32'(q1.size() != 0), 1);
                if (q1.size() != 0) begin
                    it = q1.pop_front();
                    check("ch1_out_id", 32'(bus.out_id), 32'(it.id));
                    check("ch1_out_addr", 32'(bus.out_address), 32'(it.a));
                end
            end else begin
                check("ch2_expected_item", 32'(q2.size() != 0), 1);
                if (q2.size() != 0) begin
                    it = q2.pop_front();
                    check("ch2_out_id", 32'(bus.out_id), 32'(it.id));
                    check("ch2_out_addr", 32'(bus.out_address), 32'(it.a));
                end
            end
        end
        if (bus.in_valid_1 === 1'b1 && bus.out_stall_1 === 1'b0) begin
            acc1  = 1'b1;
            it.a  = bus.in_address_1;
            it.id = bus.in_id_1;
            q1.push_back(it);
        end
        if (bus.in_valid_2 === 1'b1 && bus.out_stall_2 === 1'b0) begin
            acc2  = 1'b1;
            it.a  = bus.in_address_2;
            it.id = bus.in_id_2;
            q2.push_back(it);
        end
        if (bus.flush_1 === 1'b1) begin
            n = 0;
            for (int i = int'(q1.size()) - 1; i >= 0; i--)
                if (q1[i].id == bus.flush_id_1) begin
                    q1.delete(i);
                    n++;
                end
            exp_drop1 = (exp_drop1 + n) % 256;
        end
        if (bus.flush_2 === 1'b1) begin
            n = 0;
            for (int i = int'(q2.size()) - 1; i >= 0; i--)
                if (q2[i].id == bus.flush_id_2) begin
                    q2.delete(i);
                    n++;
                end
            exp_drop2 = (exp_drop2 + n) % 256;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            if (q1.size() == 0 && q2.size() == 0 && bus.out_valid === 1'b0)
                break;
            tick();
        end
        check("drain_q1_empty", 32'(q1.size()), 0);
        check("drain_q2_empty", 32'(q2.size()), 0);
        check("drain_out_valid", 32'(bus.out_valid), 0);
    endtask

    task automatic clear_model();
        q1.delete();
        q2.delete();
        hist.delete();
        exp_drop1 = 0;
        exp_drop2 = 0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear_model();
        reset = 1'b1;
        set1(1'b0, 8'h00, 16'h0000);
        set2(1'b0, 8'h00, 16'h0000);
        bus.flush_1    = 1'b0;
        bus.flush_id_1 = 8'h00;
        bus.flush_2    = 1'b0;
        bus.flush_id_2 = 8'h00;
        bus.out_ready  = 1'b0;
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_addr", 32'(bus.out_address), 0);
        check("rst_out_id", 32'(bus.out_id), 0);
        check("rst_out_channel", 32'(bus.out_channel), 0);
        check("rst_stall_1", 32'(bus.out_stall_1), 0);
        check("rst_stall_2", 32'(bus.out_stall_2), 0);
        check("rst_drop_1", 32'(drop_cnt_1), 0);
        check("rst_drop_2", 32'(drop_cnt_2), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single request, minimum latency
        bus.out_ready = 1'b1;
        set1(1'b1, 8'h11, 16'h0004);
        tick();
        set1(1'b0, 8'h00, 16'h0000);
        check("lat_not_yet_valid", 32'(bus.out_valid), 0);
        check("lat_stall_1", 32'(bus.out_stall_1), 0);
        tick();
        check("lat_out_valid", 32'(bus.out_valid), 1);
        check("lat_out_id", 32'(bus.out_id), 32'h11);
        check("lat_out_addr", 32'(bus.out_address), 4);
        check("lat_out_channel", 32'(bus.out_channel), 0);
        drain();

        // Fill channel 1 against a blocked output, then release
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set1(1'b1, 8'(8'h11 + k), 16'(16'hA011 + k));
            tick();
            check("fill_accept", 32'(acc1), 1);
        end
        check("fill_stall_1", 32'(bus.out_stall_1), 1);
        set1(1'b1, 8'h16, 16'hA016);
        tick();
        check("full_hold_16", 32'(acc1), 0);
        check("full_out_id", 32'(bus.out_id), 32'h11);
        check("full_stall_still", 32'(bus.out_stall_1), 1);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10 && bus.in_valid_1; k++) begin
            tick();
            if (acc1) set1(1'b0, 8'h00, 16'h0000);
        end
        check("released_16_taken", 32'(bus.in_valid_1), 0);
        check("release_stall_1", 32'(bus.out_stall_1), 0);
        drain();

        // Flush a queued entry, then the output register
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set1(1'b1, 8'(8'h12 + k), 16'(16'hB012 + k));
            tick();
        end
        set1(1'b0, 8'h00, 16'h0000);
        check("fq_stall_full", 32'(bus.out_stall_1), 1);
        bus.flush_1    = 1'b1;
        bus.flush_id_1 = 8'h16;
        tick();
        bus.flush_1 = 1'b0;
        check("fq_drop_1", 32'(drop_cnt_1), 32'(exp_drop1));
        check("fq_drop_is_one", 32'(exp_drop1), 1);
        check("fq_stall_unchanged", 32'(bus.out_stall_1), 1);
        bus.flush_1    = 1'b1;
        bus.flush_id_1 = 8'h12;
        tick();
        bus.flush_1 = 1'b0;
        check("fo_valid_cleared", 32'(bus.out_valid), 0);
        check("fo_drop_1", 32'(drop_cnt_1), 32'(exp_drop1));
        bus.out_ready = 1'b1;
        drain();

        // Flush collides with a completing handshake: transfer stands
        bus.out_ready = 1'b0;
        set1(1'b1, 8'h12, 16'hC012);
        tick();
        set1(1'b0, 8'h00, 16'h0000);
        tick();
        check("fh_loaded_id", 32'(bus.out_id), 32'h12);
        bus.out_ready  = 1'b1;
        bus.flush_1    = 1'b1;
        bus.flush_id_1 = 8'h12;
        tick();
        bus.flush_1 = 1'b0;
        check("fh_drop_1", 32'(drop_cnt_1), 32'(exp_drop1));
        drain();

        // Channel 2 flush over output register, queue and same-cycle enqueue
        bus.out_ready = 1'b0;
        set2(1'b1, 8'h2A, 16'hD001);
        tick();
        set2(1'b1, 8'h2B, 16'hD002);
        tick();
        set2(1'b1, 8'h2A, 16'hD003);
        tick();
        set2(1'b1, 8'h2A, 16'hD004);
        bus.flush_2    = 1'b1;
        bus.flush_id_2 = 8'h2A;
        tick();
        bus.flush_2 = 1'b0;
        set2(1'b0, 8'h00, 16'h0000);
        check("f2_drop_2", 32'(drop_cnt_2), 32'(exp_drop2));
        check("f2_drop_is_three", 32'(exp_drop2), 3);
        bus.out_ready = 1'b1;
        drain();

        // Round-robin alternation from reset
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_model();
        bus.out_ready = 1'b1;
        begin
            int n1;
            int n2;
            n1 = 0;
            n2 = 0;
            set1(1'b1, 8'h10, 16'hE010);
            set2(1'b1, 8'h20, 16'hF020);
            for (int k = 0; k < 10; k++) begin
                tick();
                if (acc1) n1++;
                if (acc2) n2++;
                set1(1'b1, 8'(8'h10 + n1), 16'(16'hE010 + n1));
                set2(1'b1, 8'(8'h20 + n2), 16'(16'hF020 + n2));
            end
        end
        set1(1'b0, 8'h00, 16'h0000);
        set2(1'b0, 8'h00, 16'h0000);
        drain();
        check("rr_enough_grants", 32'(hist.size() >= 6), 1);
        for (int k = 0; k < 6 && k < int'(hist.size()); k++)
            check("rr_channel_order", 32'(hist[k]), 32'(k % 2));

        // Asynchronous reset with both FIFOs partly full
        bus.out_ready = 1'b0;
        bus.flush_1    = 1'b1;
        bus.flush_id_1 = 8'h77;
        set1(1'b1, 8'h31, 16'h1031);
        set2(1'b1, 8'h41, 16'h2041);
        tick();
        bus.flush_1 = 1'b0;
        set1(1'b1, 8'h32, 16'h1032);
        set2(1'b1, 8'h42, 16'h2042);
        tick();
        set1(1'b0, 8'h00, 16'h0000);
        set2(1'b0, 8'h00, 16'h0000);
        check("pre_rst_valid", 32'(bus.out_valid), 1);
        #3;
        reset = 1'b1;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 0);
        check("arst_out_addr", 32'(bus.out_address), 0);
        check("arst_out_id", 32'(bus.out_id), 0);
        check("arst_out_channel", 32'(bus.out_channel), 0);
        check("arst_drop_1", 32'(drop_cnt_1), 0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        set2(1'b1, 8'h4A, 16'h204A);
        tick();
        set2(1'b0, 8'h00, 16'h0000);
        tick();
        check("post_rst_valid", 32'(bus.out_valid), 1);
        check("post_rst_id", 32'(bus.out_id), 32'h4A);
        check("post_rst_channel", 32'(bus.out_channel), 1);
        drain();
        check("final_drop_1", 32'(drop_cnt_1), 32'(exp_drop1));
        check("final_drop_2", 32'(drop_cnt_2), 32'(exp_drop2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
